reset_request_generator: RTL and testbench

//  Decides when the system must be reset and drives the reset_i input of the system controller.

---
 rtl/reset_request_generator_pkg.sv | 37 +++
 rtl/positive_edge_detector.sv | 22 ++
 rtl/reset_request_generator.sv | 167 ++++++++++++++++
 tb/tb_reset_request_generator.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_request_generator_pkg.sv
// Shared types and constants for the reset request generator.
package reset_request_generator_pkg;

    localparam int unsigned DEB_W   = 8;
    localparam int unsigned HOLD_W  = 4;
    localparam int unsigned WDT_W   = 16;
    localparam int unsigned CAUSE_W = 3;

    localparam int unsigned CAUSE_BUTTON = 0;
    localparam int unsigned CAUSE_WDT    = 1;
    localparam int unsigned CAUSE_SW     = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD      = 2'd1,
        WAIT_LOCK = 2'd2
    } rrg_state_e;

    // Trigger bundle; bit positions line up with the cause bit indices.
    typedef struct packed {
        logic sw;
        logic wdt;
        logic button;
    } rrg_trig_t;

    // Sticky cause update: clear drops old bits, a set in the same cycle wins.
    function automatic logic [CAUSE_W-1:0] rrg_cause_update(
        input logic [CAUSE_W-1:0] cause,
        input rrg_trig_t          trig,
        input logic               clear
    );
        logic [CAUSE_W-1:0] kept;
        kept = clear ? '0 : cause;
        return kept | CAUSE_W'(trig);
    endfunction

endpackage

// File: rtl/positive_edge_detector.sv
// Registered one-cycle pulse on each rising edge of signal.
module positive_edge_detector (
    input  logic clk,
    input  logic reset,
    input  logic signal,
    output logic edge_detected
);

    logic r_prev;

    // Remember last level and flag a 0->1 transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev        <= 1'b0;
            edge_detected <= 1'b0;
        end else begin
            r_prev        <= signal;
            edge_detected <= signal & ~r_prev;
        end
    end

endmodule

// File: rtl/reset_request_generator.sv
// Merges button, watchdog and software reset sources into one stretched
// reset request, then waits for the controller to report locked.
module reset_request_generator
    import reset_request_generator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TERMINAL = 255,
    parameter int unsigned HOLD_TERMINAL     = 15,
    parameter int unsigned WDT_TERMINAL      = 50000,
    parameter int unsigned WDT_WARN          = 40000
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               button_i,
    input  logic               sw_reset_i,
    input  logic               wdt_enable_i,
    input  logic               wdt_kick_i,
    input  logic               locked_i,
    input  logic               cause_clear_i,
    output logic               reset_req_o,
    output logic [CAUSE_W-1:0] cause_o,
    output logic               wdt_warn_o,
    output logic               busy_o
);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic [DEB_W-1:0]   r_deb_cnt;
    logic               w_btn_trig;

    logic [WDT_W-1:0]   r_wdt_cnt;
    logic               r_wdt_warn;
    logic               w_wdt_trig;

    rrg_state_e         r_state;
    rrg_state_e         w_state_next;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [HOLD_W-1:0]  w_hold_cnt_next;
    logic               r_req;
    logic               w_req_next;
    logic               r_busy;
    logic               w_busy_next;

    logic [CAUSE_W-1:0] r_cause;
    rrg_trig_t          w_trig;
    logic               w_any_trig;

    // Synchronize the button and accept a new level only after it holds steady.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_stable  <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= button_i;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_W'(DEBOUNCE_TERMINAL)) begin
                r_stable  <= r_sync2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    // Only a press (rising stable level) requests a reset.
    positive_edge_detector u_btn_edge (
        .clk           (clk_i),
        .reset         (reset_i),
        .signal        (r_stable),
        .edge_detected (w_btn_trig)
    );

    assign w_wdt_trig = (r_wdt_cnt == WDT_W'(WDT_TERMINAL));

    // Watchdog runs only while enabled and idle; kick or expiry restarts it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wdt_cnt  <= '0;
            r_wdt_warn <= 1'b0;
        end else begin
            r_wdt_warn <= (r_wdt_cnt >= WDT_W'(WDT_WARN));
            if (!wdt_enable_i || (r_state != IDLE) || wdt_kick_i || w_wdt_trig) begin
                r_wdt_cnt <= '0;
            end else begin
                r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
            end
        end
    end

    // Gather the three trigger sources.
    always_comb begin
        w_trig        = '0;
        w_trig.button = w_btn_trig;
        w_trig.wdt    = w_wdt_trig;
        w_trig.sw     = sw_reset_i;
        w_any_trig    = |w_trig;
    end

    // Next-state and next-output logic of the request sequencer.
    always_comb begin
        w_state_next    = r_state;
        w_hold_cnt_next = r_hold_cnt;
        w_req_next      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_trig) begin
                    w_state_next    = HOLD;
                    w_hold_cnt_next = '0;
                    w_req_next      = 1'b1;
                end
            end
            HOLD: begin
                if (r_hold_cnt == HOLD_W'(HOLD_TERMINAL)) begin
                    w_state_next    = WAIT_LOCK;
                    w_hold_cnt_next = '0;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
                    w_req_next      = 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (locked_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_hold_cnt_next = '0;
            end
        endcase
        w_busy_next = (w_state_next != IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_req      <= w_req_next;
            r_busy     <= w_busy_next;
        end
    end

    // Sticky cause record, set by any trigger regardless of state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cause <= '0;
        end else begin
            r_cause <= rrg_cause_update(r_cause, w_trig, cause_clear_i);
        end
    end

    assign reset_req_o = r_req;
    assign cause_o     = r_cause;
    assign wdt_warn_o  = r_wdt_warn;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_reset_request_generator.sv
// Scoreboard bench for reset_request_generator: a behavioural model pushes
// expected per-cycle status and request events; a monitor pops and compares.
module tb_reset_request_generator;

    localparam int DEB  = 7;
    localparam int HOLD = 15;
    localparam int WDT  = 100;
    localparam int WARN = 80;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       button_i = 1'b0;
    logic       sw_reset_i = 1'b0;
    logic       wdt_enable_i = 1'b0;
    logic       wdt_kick_i = 1'b0;
    logic       locked_i = 1'b0;
    logic       cause_clear_i = 1'b0;
    logic       reset_req_o;
    logic [2:0] cause_o;
    logic       wdt_warn_o;
    logic       busy_o;

    reset_request_generator #(
        .DEBOUNCE_TERMINAL (DEB),
        .HOLD_TERMINAL     (HOLD),
        .WDT_TERMINAL      (WDT),
        .WDT_WARN          (WARN)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .button_i      (button_i),
        .sw_reset_i    (sw_reset_i),
        .wdt_enable_i  (wdt_enable_i),
        .wdt_kick_i    (wdt_kick_i),
        .locked_i      (locked_i),
        .cause_clear_i (cause_clear_i),
        .reset_req_o   (reset_req_o),
        .cause_o       (cause_o),
        .wdt_warn_o    (wdt_warn_o),
        .busy_o        (busy_o)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         cyc;
        logic       req;
        logic [2:0] cause;
        logic       warn;
        logic       busy;
    } status_t;

    typedef struct {
        int         cyc;
        logic [2:0] cause;
    } req_ev_t;

    status_t stat_q[$];
    req_ev_t ev_q[$];

    // Model state, expressed as elapsed times and run lengths.
    int       cyc        = 0;
    bit       m_busy     = 1'b0;
    int       m_start    = 0;
    bit [2:0] m_cause    = 3'b000;
    int       m_wdt_run  = 0;
    bit       m_stable   = 1'b0;
    int       m_diff_run = 0;
    bit       btn_q[$]   = '{1'b0, 1'b0};
    bit       rise_q[$]  = '{1'b0, 1'b0};

    // Behavioural reference model, evaluated at every active edge.
    always @(posedge clk) begin : model
        status_t s;
        bit      b_trig;
        bit      w_trig;
        bit      prev_busy;
        bit      seen_lvl;
        bit      rise;
        cyc++;
        s.cyc = cyc;
        if (reset_i) begin
            m_busy     = 1'b0;
            m_cause    = 3'b000;
            m_wdt_run  = 0;
            m_stable   = 1'b0;
            m_diff_run = 0;
            btn_q      = '{1'b0, 1'b0};
            rise_q     = '{1'b0, 1'b0};
            s.req   = 1'b0;
            s.cause = 3'b000;
            s.warn  = 1'b0;
            s.busy  = 1'b0;
        end else begin
            // button seen two cycles late; a press is acted on two cycles after acceptance
            seen_lvl = btn_q[0];
            btn_q.push_back(button_i);
            void'(btn_q.pop_front());
            b_trig = rise_q[0];
            rise = 1'b0;
            if (seen_lvl != m_stable) begin
                m_diff_run++;
                if (m_diff_run == DEB + 1) begin
                    m_stable   = seen_lvl;
                    m_diff_run = 0;
                    rise       = seen_lvl;
                end
            end else begin
                m_diff_run = 0;
            end
            rise_q.push_back(rise);
            void'(rise_q.pop_front());

            w_trig    = (m_wdt_run == WDT);
            s.warn    = (m_wdt_run >= WARN);
            prev_busy = m_busy;

            m_cause = (cause_clear_i ? 3'b000 : m_cause) | {sw_reset_i, w_trig, b_trig};

            if (!m_busy && (sw_reset_i || w_trig || b_trig)) begin
                req_ev_t ev;
                m_busy    = 1'b1;
                m_start   = cyc;
                ev.cyc    = cyc;
                ev.cause  = m_cause;
                ev_q.push_back(ev);
            end else if (m_busy && (cyc - m_start) >= HOLD + 2 && locked_i) begin
                m_busy = 1'b0;
            end

            if (wdt_enable_i && !wdt_kick_i && !prev_busy && !w_trig) m_wdt_run++;
            else m_wdt_run = 0;

            s.req   = m_busy && ((cyc - m_start) <= HOLD);
            s.cause = m_cause;
            s.busy  = m_busy;
        end
        stat_q.push_back(s);
    end

    logic prev_req = 1'b0;

    // Monitor: compare every presented cycle, and match each new request.
    always @(negedge clk) begin : monitor
        status_t e;
        req_ev_t r;
        if (stat_q.size() > 0) begin
            e = stat_q.pop_front();
            n_checks++;
            if (reset_req_o !== e.req || cause_o !== e.cause ||
                wdt_warn_o !== e.warn || busy_o !== e.busy) begin
                n_fail++;
                $display("FAIL status cyc=%0d got req=%b cause=%b warn=%b busy=%b want req=%b cause=%b warn=%b busy=%b",
                         e.cyc, reset_req_o, cause_o, wdt_warn_o, busy_o, e.req, e.cause, e.warn, e.busy);
            end
        end
        if (reset_req_o === 1'b1 && prev_req !== 1'b1) begin
            n_checks++;
            if (ev_q.size() == 0) begin
                n_fail++;
                $display("FAIL request_event cyc=%0d got unexpected request, want none", cyc);
            end else begin
                r = ev_q.pop_front();
                if (r.cyc != cyc || cause_o !== r.cause) begin
                    n_fail++;
                    $display("FAIL request_event got cyc=%0d cause=%b want cyc=%0d cause=%b",
                             cyc, cause_o, r.cyc, r.cause);
                end
            end
        end
        prev_req = reset_req_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic clear_cause();
        cause_clear_i = 1'b1;
        step();
        cause_clear_i = 1'b0;
    endtask

    initial begin : timeout
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int hi;
        int lat;
        int cnt;
        bit saw_warn;
        int hold_left;

        // power-on reset
        reset_i = 1'b1;
        repeat (3) step();
        reset_i = 1'b0;
        check("reset req", int'(reset_req_o), 0);
        check("reset cause", int'(cause_o), 0);
        check("reset warn", int'(wdt_warn_o), 0);
        check("reset busy", int'(busy_o), 0);

        // quiet period
        repeat (200) step();
        check("quiet req", int'(reset_req_o), 0);
        check("quiet busy", int'(busy_o), 0);
        check("quiet cause", int'(cause_o), 0);

        // software request, locked arrives late
        locked_i   = 1'b0;
        sw_reset_i = 1'b1;
        step();
        sw_reset_i = 1'b0;
        check("sw req start", int'(reset_req_o), 1);
        hi = 1;
        for (int i = 1; i <= 20; i++) begin
            step();
            hi += int'(reset_req_o);
        end
        locked_i = 1'b1;
        check("sw busy before lock", int'(busy_o), 1);
        step();
        check("sw busy after lock", int'(busy_o), 0);
        check("sw high cycles", hi, HOLD + 1);
        check("sw cause", int'(cause_o), 3'b100);
        clear_cause();

        // bouncy button, then a firm press
        for (int s = 0; s < 10; s++) begin
            button_i = (s % 2 == 0);
            repeat (3) step();
        end
        button_i = 1'b1;
        lat = -1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (reset_req_o) begin
                lat = i;
                break;
            end
        end
        check("button latency", lat, 2 + DEB + 1 + 1);
        check("button cause", int'(cause_o), 3'b001);
        repeat (60) step();
        button_i = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cnt += int'(reset_req_o);
        end
        check("button release no request", cnt, 0);
        clear_cause();

        // watchdog serviced every 90 cycles, then abandoned
        wdt_enable_i = 1'b1;
        saw_warn = 1'b0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            wdt_kick_i = 1'b1;
            step();
            wdt_kick_i = 1'b0;
            for (int j = 0; j < 89; j++) begin
                step();
                saw_warn |= wdt_warn_o;
                cnt += int'(reset_req_o);
            end
        end
        check("wdt kicked warn seen", int'(saw_warn), 1);
        check("wdt kicked no request", cnt, 0);
        repeat (120) step();
        check("wdt cause", int'(cause_o[1]), 1);
        wdt_enable_i = 1'b0;
        step();
        clear_cause();

        // watchdog expiry coincides with a software pulse
        locked_i     = 1'b0;
        wdt_enable_i = 1'b1;
        wdt_kick_i   = 1'b1;
        step();
        wdt_kick_i = 1'b0;
        repeat (WDT) step();
        sw_reset_i = 1'b1;
        step();
        sw_reset_i   = 1'b0;
        wdt_enable_i = 1'b0;
        check("dual req", int'(reset_req_o), 1);
        check("dual cause", int'(cause_o), 3'b110);
        repeat (20) step();
        cause_clear_i = 1'b1;
        sw_reset_i    = 1'b1;
        step();
        cause_clear_i = 1'b0;
        sw_reset_i    = 1'b0;
        check("clear vs set cause", int'(cause_o), 3'b100);
        check("no restart in wait", int'(reset_req_o), 0);
        check("still waiting", int'(busy_o), 1);
        locked_i = 1'b1;
        repeat (3) step();
        check("dual done", int'(busy_o), 0);

        // abort in HOLD
        locked_i   = 1'b0;
        sw_reset_i = 1'b1;
        step();
        sw_reset_i = 1'b0;
        repeat (5) step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("abort req", int'(reset_req_o), 0);
        check("abort busy", int'(busy_o), 0);
        check("abort cause", int'(cause_o), 0);
        repeat (3) step();

        // randomized traffic
        hold_left = 1;
        for (int i = 0; i < 3000; i++) begin
            hold_left--;
            if (hold_left <= 0) begin
                button_i  = ~button_i;
                hold_left = int'($urandom_range(1, 20));
            end
            if ($urandom_range(0, 299) == 0) wdt_enable_i = ~wdt_enable_i;
            wdt_kick_i    = wdt_enable_i && ($urandom_range(0, 69) == 0);
            sw_reset_i    = ($urandom_range(0, 199) == 0);
            locked_i      = ($urandom_range(0, 3) != 0);
            cause_clear_i = ($urandom_range(0, 99) == 0);
            reset_i       = ($urandom_range(0, 999) == 0);
            step();
        end
        reset_i = 1'b0; sw_reset_i = 1'b0; wdt_kick_i = 1'b0;
        wdt_enable_i = 1'b0; cause_clear_i = 1'b0; button_i = 1'b0;
        locked_i = 1'b1;
        repeat (40) step();
        check("pending request events", ev_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
